banked_data_memory: RTL and testbench

- Parametrised successor to the team's 4-lane byte-banked data RAM.
- Adds a registered request/valid handshake, sign/zero-extended loads, and real support for unaligned word access (size 2) through a two-cycle split FSM.
- Adds address-window and alignment error reporting.
- Sits on the processor's load/store path as the data memory, decoded by the upper 16 address bits.

---
 rtl/banked_data_memory.sv | 234 +++++++++++++++++++++++
 tb/tb_banked_data_memory.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_data_memory.sv
// rtl/banked_data_memory.sv - 4-lane byte-banked data RAM with split unaligned word access
//
// Purpose:
//   Data memory on the load/store path, selected when addr_in[31:16] == MEM_ADDR.
//   Four byte lanes, little-endian. Byte/half/word loads and stores, with loads
//   sign- or zero-extended. An unaligned word (size 2, offset != 0) is split over
//   two cycles: the accept edge handles word w, the SPLIT edge handles word w+1.
//
// Ports:
//   clock        in   single clock, rising edge
//   reset        in   synchronous, active-high
//   req_in       in   request strobe, accepted when busy_out = 0
//   addr_in      in   byte address
//   data_in      in   store data, right-justified
//   size_in      in   0 byte, 1 half, 2 unaligned word, 3 aligned word
//   we_in        in   1 store, 0 load
//   sign_ext_in  in   loads: 1 sign-extend, 0 zero-extend
//   busy_out     out  high during the second half of a split access
//   valid_out    out  one-cycle completion pulse
//   data_out     out  registered load result, held until the next valid_out
//   err_out      out  pulses with valid_out when an access is rejected

module banked_data_memory #(
  parameter logic [15:0] MEM_ADDR      = 16'h1000,
  parameter int          NUM_WORDS     = 1024,
  parameter bit          DO_INIT       = 1'b0,
  parameter              INIT_PROGRAM0 = "ram.memh",
  parameter              INIT_PROGRAM1 = "ram.memh",
  parameter              INIT_PROGRAM2 = "ram.memh",
  parameter              INIT_PROGRAM3 = "ram.memh"
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_in,
  input  logic [1:0]  size_in,
  input  logic        we_in,
  input  logic        sign_ext_in,
  output logic        busy_out,
  output logic        valid_out,
  output logic [31:0] data_out,
  output logic        err_out
);

  localparam int NUM_WORDS_LOG = $clog2(NUM_WORDS);

  typedef logic [NUM_WORDS_LOG-1:0] idx_t;
  typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;

  // Byte lanes: lane k holds bits 8k+7:8k of every word.
  logic [7:0] lane0_mem [NUM_WORDS];
  logic [7:0] lane1_mem [NUM_WORDS];
  logic [7:0] lane2_mem [NUM_WORDS];
  logic [7:0] lane3_mem [NUM_WORDS];

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [31:0] data_out_q, data_out_d;
  logic [31:0] lo_q, lo_d;         // split load: bytes o..3 of word w, right-justified
  logic [31:0] sp_data_q, sp_data_d;
  logic [1:0]  sp_off_q, sp_off_d;
  idx_t        sp_w_q, sp_w_d;
  logic        sp_we_q, sp_we_d;

  // Request decode
  logic [1:0]  off;
  idx_t        cur_w;
  idx_t        nxt_w;
  logic [15:0] addr_hi_bits;
  logic        accept;
  logic        acc_split;
  logic        acc_err;

  assign off          = addr_in[1:0];
  assign cur_w        = addr_in[NUM_WORDS_LOG+1:2];
  assign nxt_w        = sp_w_q + idx_t'(1);
  assign addr_hi_bits = addr_in[15:0] >> (NUM_WORDS_LOG + 2);
  assign accept       = req_in && (state_q == IDLE);
  assign acc_split    = (size_in == 2'd2) && (off != 2'd0);

  always_comb begin
    acc_err = 1'b0;
    if (addr_in[31:16] != MEM_ADDR)               acc_err = 1'b1;
    if (addr_hi_bits != 16'd0)                    acc_err = 1'b1;
    if ((size_in == 2'd1) && off[0])              acc_err = 1'b1;
    if ((size_in == 2'd3) && (off != 2'd0))       acc_err = 1'b1;
    // No wrap-around past the last word.
    if (acc_split && (cur_w == idx_t'(NUM_WORDS - 1))) acc_err = 1'b1;
  end

  logic [31:0] rd_cur;
  logic [31:0] rd_nxt;
  assign rd_cur = {lane3_mem[cur_w], lane2_mem[cur_w], lane1_mem[cur_w], lane0_mem[cur_w]};
  assign rd_nxt = {lane3_mem[nxt_w], lane2_mem[nxt_w], lane1_mem[nxt_w], lane0_mem[nxt_w]};

  // Rotate so that lane k carries store byte (k - o) mod 4. The same rotation
  // serves both halves of a split store.
  function automatic logic [31:0] rotl_bytes(input logic [31:0] d, input logic [1:0] o);
    case (o)
      2'd0:    return d;
      2'd1:    return {d[23:0], d[31:24]};
      2'd2:    return {d[15:0], d[31:16]};
      default: return {d[7:0],  d[31:8]};
    endcase
  endfunction

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !acc_err && acc_split) state_d = SPLIT;
      SPLIT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic
  logic [3:0]  wr_en;
  idx_t        wr_idx;
  logic [31:0] wr_data;
  logic [31:0] shifted;

  always_comb begin
    valid_d    = 1'b0;
    err_d      = 1'b0;
    data_out_d = data_out_q;
    lo_d       = lo_q;
    sp_data_d  = sp_data_q;
    sp_off_d   = sp_off_q;
    sp_w_d     = sp_w_q;
    sp_we_d    = sp_we_q;
    wr_en      = 4'b0000;
    wr_idx     = cur_w;
    wr_data    = rotl_bytes(data_in, off);
    shifted    = rd_cur >> {off, 3'b000};

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (acc_err) begin
            valid_d    = 1'b1;
            err_d      = 1'b1;
            data_out_d = 32'd0;
          end else if (acc_split) begin
            sp_data_d = data_in;
            sp_off_d  = off;
            sp_w_d    = cur_w;
            sp_we_d   = we_in;
            if (we_in) wr_en = 4'b1111 << off;   // lanes o..3 of word w
            else       lo_d  = shifted;
          end else begin
            valid_d = 1'b1;
            if (we_in) begin
              case (size_in)
                2'd0:    wr_en = 4'b0001 << off;
                2'd1:    wr_en = 4'b0011 << off;
                default: wr_en = 4'b1111;
              endcase
            end else begin
              case (size_in)
                2'd0:    data_out_d = {{24{shifted[7] & sign_ext_in}}, shifted[7:0]};
                2'd1:    data_out_d = {{16{shifted[15] & sign_ext_in}}, shifted[15:0]};
                default: data_out_d = shifted;
              endcase
            end
          end
        end
      end
      SPLIT: begin
        valid_d = 1'b1;
        wr_idx  = nxt_w;
        wr_data = rotl_bytes(sp_data_q, sp_off_q);
        if (sp_we_q) begin
          wr_en = ~(4'b1111 << sp_off_q);        // lanes 0..o-1 of word w+1
        end else begin
          case (sp_off_q)
            2'd1:    data_out_d = {rd_nxt[7:0],  lo_q[23:0]};
            2'd2:    data_out_d = {rd_nxt[15:0], lo_q[15:0]};
            2'd3:    data_out_d = {rd_nxt[23:0], lo_q[7:0]};
            default: data_out_d = lo_q;
          endcase
        end
      end
      default: ;
    endcase
  end

  // Control and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      data_out_q <= 32'd0;
      lo_q       <= 32'd0;
      sp_data_q  <= 32'd0;
      sp_off_q   <= 2'd0;
      sp_w_q     <= '0;
      sp_we_q    <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      err_q      <= err_d;
      data_out_q <= data_out_d;
      lo_q       <= lo_d;
      sp_data_q  <= sp_data_d;
      sp_off_q   <= sp_off_d;
      sp_w_q     <= sp_w_d;
      sp_we_q    <= sp_we_d;
    end
  end

  // RAM write port; reset blocks the pending half of an aborted split store.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (wr_en[0]) lane0_mem[wr_idx] <= wr_data[7:0];
      if (wr_en[1]) lane1_mem[wr_idx] <= wr_data[15:8];
      if (wr_en[2]) lane2_mem[wr_idx] <= wr_data[23:16];
      if (wr_en[3]) lane3_mem[wr_idx] <= wr_data[31:24];
    end
  end

  assign busy_out  = (state_q == SPLIT);
  assign valid_out = valid_q;
  assign err_out   = err_q;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_banked_data_memory.sv
// tb/tb_banked_data_memory.sv - randomized self-checking bench for banked_data_memory

module tb_banked_data_memory;

  localparam logic [15:0] MEM_ADDR  = 16'h1000;
  localparam int          NUM_WORDS = 1024;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_in;
  logic [31:0] addr_in;
  logic [31:0] data_in;
  logic [1:0]  size_in;
  logic        we_in;
  logic        sign_ext_in;
  logic        busy_out;
  logic        valid_out;
  logic [31:0] data_out;
  logic        err_out;

  banked_data_memory #(
    .MEM_ADDR  (MEM_ADDR),
    .NUM_WORDS (NUM_WORDS)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_in      (req_in),
    .addr_in     (addr_in),
    .data_in     (data_in),
    .size_in     (size_in),
    .we_in       (we_in),
    .sign_ext_in (sign_ext_in),
    .busy_out    (busy_out),
    .valid_out   (valid_out),
    .data_out    (data_out),
    .err_out     (err_out)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Byte-addressed reference memory covering the whole window.
  logic [7:0]  mem_m [NUM_WORDS*4];
  logic [31:0] last_dout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit model_err(input logic [31:0] a, input logic [1:0] s);
    int lo;
    lo = int'(a[15:0]);
    if (a[31:16] != MEM_ADDR)                         return 1'b1;
    if (lo >= NUM_WORDS*4)                            return 1'b1;
    if (s == 2'd1 && (lo % 2) != 0)                   return 1'b1;
    if (s == 2'd3 && (lo % 4) != 0)                   return 1'b1;
    if (s == 2'd2 && (lo % 4) != 0 && lo + 4 > NUM_WORDS*4) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s, input logic sx);
    logic [31:0] v;
    int base;
    base = int'(a[15:0]);
    v = 32'd0;
    for (int i = 0; i < nbytes(s); i++)
      v = v | ({24'd0, mem_m[base + i]} << (8 * i));
    if (s == 2'd0 && sx && v[7])  v = v | 32'hFFFF_FF00;
    if (s == 2'd1 && sx && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    int base;
    base = int'(a[15:0]);
    for (int i = 0; i < nbytes(s); i++)
      mem_m[base + i] = d[8*i +: 8];
  endtask

  // One complete access with latency, busy, error and result checks.
  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                        input logic we, input logic sx, input string tag);
    bit          e;
    bit          split;
    logic [31:0] v;
    int          lat;
    e     = model_err(a, s);
    split = !e && (s == 2'd2) && (a[1:0] != 2'd0);
    if (e)       v = 32'd0;
    else if (we) begin model_store(a, d, s); v = last_dout; end
    else         v = model_load(a, s, sx);

    @(negedge clock);
    req_in = 1'b1; addr_in = a; data_in = d; size_in = s; we_in = we; sign_ext_in = sx;
    @(negedge clock);
    req_in = 1'b0;
    check({tag, ".busy"}, {31'd0, busy_out}, {31'd0, split});
    lat = 1;
    while (!valid_out && lat < 6) begin
      @(negedge clock);
      lat++;
    end
    check({tag, ".lat"},  lat, split ? 2 : 1);
    check({tag, ".err"},  {31'd0, err_out}, {31'd0, e});
    check({tag, ".data"}, data_out, v);
    last_dout = v;
  endtask

  initial begin
    int vcount;
    logic [31:0] a;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [1:0]  s;

    reset = 1'b1; req_in = 1'b0; addr_in = 32'd0; data_in = 32'd0;
    size_in = 2'd0; we_in = 1'b0; sign_ext_in = 1'b0;
    repeat (3) @(negedge clock);
    check("rst.busy",  {31'd0, busy_out},  32'd0);
    check("rst.valid", {31'd0, valid_out}, 32'd0);
    check("rst.err",   {31'd0, err_out},   32'd0);
    check("rst.data",  data_out,           32'd0);
    reset = 1'b0;
    last_dout = 32'd0;

    // Known contents for the regions exercised below.
    for (int w = 0; w < 32; w++)
      access(32'h1000_0000 + 32'(4 * w), 32'd0, 2'd3, 1'b1, 1'b0, "zero");
    for (int w = NUM_WORDS - 4; w < NUM_WORDS; w++)
      access(32'h1000_0000 + 32'(4 * w), 32'd0, 2'd3, 1'b1, 1'b0, "zero_top");

    access(32'h1000_0010, 32'hDEAD_BEEF, 2'd3, 1'b1, 1'b0, "st_word");
    access(32'h1000_0010, 32'd0,         2'd3, 1'b0, 1'b0, "ld_word");
    check("ld_word.value", data_out, 32'hDEAD_BEEF);

    access(32'h1000_0013, 32'h0000_0080, 2'd0, 1'b1, 1'b0, "st_byte");
    access(32'h1000_0013, 32'd0, 2'd0, 1'b0, 1'b1, "ld_byte_sx");
    check("ld_byte_sx.value", data_out, 32'hFFFF_FF80);
    access(32'h1000_0013, 32'd0, 2'd0, 1'b0, 1'b0, "ld_byte_zx");
    check("ld_byte_zx.value", data_out, 32'h0000_0080);
    access(32'h1000_0010, 32'd0, 2'd3, 1'b0, 1'b0, "ld_word_lanes");
    check("ld_word_lanes.value", data_out, 32'h80AD_BEEF);

    access(32'h1000_0021, 32'h1122_3344, 2'd2, 1'b1, 1'b0, "st_unal");
    access(32'h1000_0020, 32'd0, 2'd3, 1'b0, 1'b0, "ld_w20");
    check("ld_w20.value", data_out, 32'h2233_4400);
    access(32'h1000_0024, 32'd0, 2'd3, 1'b0, 1'b0, "ld_w24");
    check("ld_w24.value", data_out, 32'h0000_0011);
    access(32'h1000_0021, 32'd0, 2'd2, 1'b0, 1'b0, "ld_unal");
    check("ld_unal.value", data_out, 32'h1122_3344);

    access(32'h2000_0000, 32'd0,         2'd3, 1'b0, 1'b0, "err_window");
    access(32'h1000_0001, 32'h0000_ABCD, 2'd1, 1'b1, 1'b0, "err_half");
    access(32'h1000_0000, 32'd0,         2'd3, 1'b0, 1'b0, "err_half_chk");
    access(32'h1000_0002, 32'hCAFE_F00D, 2'd3, 1'b1, 1'b0, "err_word");
    access(32'h1000_0000, 32'd0,         2'd3, 1'b0, 1'b0, "err_word_chk");
    access(32'h1000_0FFD, 32'h5566_7788, 2'd2, 1'b1, 1'b0, "err_wrap");
    access(32'h1000_0FFC, 32'd0,         2'd3, 1'b0, 1'b0, "err_wrap_chk");

    // Request held through SPLIT with a different address: must be ignored.
    exp_a = model_load(32'h1000_0021, 2'd2, 1'b0);
    @(negedge clock);
    req_in = 1'b1; addr_in = 32'h1000_0021; size_in = 2'd2; we_in = 1'b0; sign_ext_in = 1'b0;
    @(negedge clock);
    vcount = valid_out ? 1 : 0;
    addr_in = 32'h1000_0030; data_in = 32'h55AA_55AA; size_in = 2'd3; we_in = 1'b1;
    @(negedge clock);
    req_in = 1'b0;
    if (valid_out) vcount++;
    check("hold.data", data_out, exp_a);
    last_dout = exp_a;
    repeat (3) begin
      @(negedge clock);
      if (valid_out) vcount++;
    end
    check("hold.valid_count", vcount, 1);
    access(32'h1000_0030, 32'd0, 2'd3, 1'b0, 1'b0, "hold_chk");

    // Back-to-back single-cycle loads.
    exp_a = model_load(32'h1000_0010, 2'd3, 1'b0);
    exp_b = model_load(32'h1000_0013, 2'd0, 1'b0);
    @(negedge clock);
    req_in = 1'b1; addr_in = 32'h1000_0010; size_in = 2'd3; we_in = 1'b0; sign_ext_in = 1'b0;
    @(negedge clock);
    addr_in = 32'h1000_0013; size_in = 2'd0;
    check("b2b.valid0", {31'd0, valid_out}, 32'd1);
    check("b2b.data0",  data_out, exp_a);
    @(negedge clock);
    req_in = 1'b0;
    check("b2b.valid1", {31'd0, valid_out}, 32'd1);
    check("b2b.data1",  data_out, exp_b);
    last_dout = exp_b;

    // Reset during SPLIT of an unaligned store.
    @(negedge clock);
    req_in = 1'b1; addr_in = 32'h1000_0042; data_in = 32'hA1B2_C3D4; size_in = 2'd2; we_in = 1'b1;
    @(negedge clock);
    req_in = 1'b0; reset = 1'b1;
    check("rsplit.busy", {31'd0, busy_out}, 32'd1);
    @(negedge clock);
    reset = 1'b0;
    check("rsplit.busy_after", {31'd0, busy_out}, 32'd0);
    check("rsplit.data_after", data_out, 32'd0);
    vcount = valid_out ? 1 : 0;
    repeat (3) begin
      @(negedge clock);
      if (valid_out) vcount++;
    end
    check("rsplit.valid_count", vcount, 0);
    mem_m[16'h0042] = 8'hD4;
    mem_m[16'h0043] = 8'hC3;
    last_dout = 32'd0;
    access(32'h1000_0040, 32'd0, 2'd3, 1'b0, 1'b0, "rsplit_w10");
    check("rsplit_w10.value", data_out, 32'hC3D4_0000);
    access(32'h1000_0044, 32'd0, 2'd3, 1'b0, 1'b0, "rsplit_w11");
    check("rsplit_w11.value", data_out, 32'h0000_0000);

    // Randomized mix against the byte-level model.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 15))
        0: a = 32'h2000_0000 | 32'($urandom_range(0, 63));
        1: a = 32'h1000_1000 + 32'($urandom_range(0, 255));
        2, 3: a = 32'h1000_0FF0 + 32'($urandom_range(0, 15));
        default: a = 32'h1000_0000 + 32'($urandom_range(0, 63));
      endcase
      s = 2'($urandom_range(0, 3));
      access(a, $urandom, s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
